// File: rtl/code_loader.sv
// Byte-stream program loader: frames a program image and writes it into the code RAM as 16-bit words.
// Optional checksum byte and FAIL handling are enabled with `define CODE_LOADER_CHECKSUM_EN.
module code_loader #(
    parameter logic [7:0] START_BYTE   = 8'hA5,
    parameter logic [7:0] BASE_ADDRESS = 8'h00
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic [7:0]  WR_ADDRESS,
    output logic [15:0] WR_DATA,
    output logic        WR_EN,
    output logic        CPU_HOLD,
    output logic        DONE,
    output logic        ERROR
);

`ifdef CODE_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN    = 3'd1,
        S_HI     = 3'd2,
        S_LO     = 3'd3,
        S_WRITE  = 3'd4,
        S_CHK    = 3'd5,
        S_FINISH = 3'd6,
        S_FAIL   = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN    = 3'd1,
        S_HI     = 3'd2,
        S_LO     = 3'd3,
        S_WRITE  = 3'd4,
        S_FINISH = 3'd6,
        S_FAIL   = 3'd7
    } state_t;
`endif

`ifdef CODE_LOADER_CHECKSUM_EN
    // Running mod-256 sum; a frame is good when data sum plus checksum byte is zero.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction
`endif

    state_t      state_r;
    state_t      state_s;
    state_t      last_s;
    logic        accept_s;
    logic        is_start_s;
    logic [8:0]  count_r;
    logic [8:0]  words_r;
`ifdef CODE_LOADER_CHECKSUM_EN
    logic [7:0]  csum_r;
`endif

    assign accept_s   = RX_VALID & RX_READY;
    assign is_start_s = (RX_DATA == START_BYTE);

`ifdef CODE_LOADER_CHECKSUM_EN
    assign last_s = S_CHK;
`else
    assign last_s = S_FINISH;
    assign ERROR  = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; START_BYTE only restarts from the idle/terminal states.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE, S_FINISH, S_FAIL: begin
                if (accept_s && is_start_s) begin
                    state_s = S_LEN;
                end else begin
                    state_s = state_r;
                end
            end
            S_LEN: begin
                if (accept_s) begin
                    state_s = S_HI;
                end else begin
                    state_s = S_LEN;
                end
            end
            S_HI: begin
                if (accept_s) begin
                    state_s = S_LO;
                end else begin
                    state_s = S_HI;
                end
            end
            S_LO: begin
                if (accept_s) begin
                    state_s = S_WRITE;
                end else begin
                    state_s = S_LO;
                end
            end
            S_WRITE: begin
                if ((count_r + 9'd1) == words_r) begin
                    state_s = last_s;
                end else begin
                    state_s = S_HI;
                end
            end
`ifdef CODE_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (!accept_s) begin
                    state_s = S_CHK;
                end else if (csum_add(csum_r, RX_DATA) == 8'd0) begin
                    state_s = S_FINISH;
                end else begin
                    state_s = S_FAIL;
                end
            end
`endif
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Status/handshake outputs are registered copies of what the next state implies.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            RX_READY <= 1'b1;
            WR_EN    <= 1'b0;
            CPU_HOLD <= 1'b0;
            DONE     <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
            ERROR    <= 1'b0;
`endif
        end else begin
            RX_READY <= (state_s != S_WRITE);
            WR_EN    <= (state_s == S_WRITE);
            CPU_HOLD <= (state_s != S_IDLE) && (state_s != S_FINISH);
            DONE     <= (state_s == S_FINISH);
`ifdef CODE_LOADER_CHECKSUM_EN
            ERROR    <= (state_s == S_FAIL);
`endif
        end
    end

    // Datapath: word assembly, address/count stepping and checksum accumulation.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WR_ADDRESS <= BASE_ADDRESS;
            WR_DATA    <= 16'h0000;
            count_r    <= 9'd0;
            words_r    <= 9'd0;
`ifdef CODE_LOADER_CHECKSUM_EN
            csum_r     <= 8'd0;
`endif
        end else begin
            if ((state_r == S_LEN) && accept_s) begin
                // A length byte of zero encodes a full 256-word image.
                words_r    <= (RX_DATA == 8'd0) ? 9'd256 : {1'b0, RX_DATA};
                count_r    <= 9'd0;
                WR_ADDRESS <= BASE_ADDRESS;
`ifdef CODE_LOADER_CHECKSUM_EN
                csum_r     <= 8'd0;
`endif
            end else if ((state_r == S_HI) && accept_s) begin
                WR_DATA[15:8] <= RX_DATA;
`ifdef CODE_LOADER_CHECKSUM_EN
                csum_r        <= csum_add(csum_r, RX_DATA);
`endif
            end else if ((state_r == S_LO) && accept_s) begin
                WR_DATA[7:0] <= RX_DATA;
`ifdef CODE_LOADER_CHECKSUM_EN
                csum_r       <= csum_add(csum_r, RX_DATA);
`endif
            end else if (state_r == S_WRITE) begin
                WR_ADDRESS <= WR_ADDRESS + 8'd1;
                count_r    <= count_r + 9'd1;
            end else begin
                WR_ADDRESS <= WR_ADDRESS;
                count_r    <= count_r;
            end
        end
    end

endmodule

// File: tb/tb_code_loader.sv
// Scoreboard bench for code_loader: randomized frames, expected RAM writes queued per word and
// checked by an independent write monitor; honours CODE_LOADER_CHECKSUM_EN when defined.
module tb_code_loader;

    localparam logic [7:0] START = 8'hA5;
    localparam logic [7:0] BASE  = 8'hFE;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic [7:0]  WR_ADDRESS;
    logic [15:0] WR_DATA;
    logic        WR_EN;
    logic        CPU_HOLD;
    logic        DONE;
    logic        ERROR;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [23:0] exp_q [$];
    logic [15:0] frame_words [256];
    logic        prev_wr = 1'b0;

    code_loader #(.START_BYTE(START), .BASE_ADDRESS(BASE)) dut (
        .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .WR_ADDRESS(WR_ADDRESS), .WR_DATA(WR_DATA), .WR_EN(WR_EN), .CPU_HOLD(CPU_HOLD),
        .DONE(DONE), .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge CLK) begin
        logic [23:0] e;
        if (RESET) begin
            prev_wr = 1'b0;
        end else begin
            check("ready_vs_write", {31'd0, RX_READY}, {31'd0, ~WR_EN});
            if (WR_EN) begin
                check("write_back_to_back", {31'd0, prev_wr}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %h data %h, no write expected", WR_ADDRESS, WR_DATA);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", {24'd0, WR_ADDRESS}, {24'd0, e[23:16]});
                    check("write_data", {16'd0, WR_DATA}, {16'd0, e[15:0]});
                end
            end
            prev_wr = WR_EN;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one byte after a random idle gap and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int budget;
        gap = $urandom_range(max_gap, 0);
        repeat (gap) tick();
        RX_DATA  = b;
        RX_VALID = 1'b1;
        budget   = 0;
        while (!RX_READY && budget < 20) begin
            tick();
            budget++;
        end
        if (!RX_READY) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: RX_READY stuck at 0, required 1");
        end
        tick();
        RX_VALID = 1'b0;
        RX_DATA  = 8'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {31'd0, RX_READY}, 32'd1);
        check({tag, "_wren"},  {31'd0, WR_EN}, 32'd0);
        check({tag, "_addr"},  {24'd0, WR_ADDRESS}, {24'd0, BASE});
        check({tag, "_data"},  {16'd0, WR_DATA}, 32'd0);
        check({tag, "_hold"},  {31'd0, CPU_HOLD}, 32'd0);
        check({tag, "_done"},  {31'd0, DONE}, 32'd0);
        check({tag, "_error"}, {31'd0, ERROR}, 32'd0);
    endtask

    // Reference: word i lands at BASE+i (mod 256); checksum makes the byte sum zero mod 256.
    task automatic run_frame(input logic [7:0] n, input bit bad, input int max_gap);
        int         cnt;
        logic [7:0] sum;
        logic [7:0] a;
        bit         exp_ok;
        cnt = (n == 8'd0) ? 256 : int'(n);
        sum = 8'd0;
        send_byte(START, max_gap);
        send_byte(n, max_gap);
        check("hold_while_loading", {31'd0, CPU_HOLD}, 32'd1);
        check("done_while_loading", {31'd0, DONE}, 32'd0);
        check("error_while_loading", {31'd0, ERROR}, 32'd0);
        for (int i = 0; i < cnt; i++) begin
            a = BASE + i[7:0];
            exp_q.push_back({a, frame_words[i]});
            sum = sum + frame_words[i][15:8] + frame_words[i][7:0];
            send_byte(frame_words[i][15:8], max_gap);
            send_byte(frame_words[i][7:0], max_gap);
        end
`ifdef CODE_LOADER_CHECKSUM_EN
        send_byte(8'd0 - sum + (bad ? 8'd1 : 8'd0), max_gap);
        exp_ok = !bad;
`else
        exp_ok = !bad;
`endif
        repeat (3) tick();
        check("final_done",  {31'd0, DONE}, {31'd0, exp_ok});
        check("final_hold",  {31'd0, CPU_HOLD}, {31'd0, !exp_ok});
        check("final_error", {31'd0, ERROR}, {31'd0, !exp_ok});
        check("writes_outstanding", exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] n;
        bit         bad;
        RESET    = 1'b1;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        repeat (3) tick();
        RESET = 1'b0;
        tick();
        check_reset_values("reset");

        // Reference frame 1234, ABCD at FE/FF.
        frame_words[0] = 16'h1234;
        frame_words[1] = 16'hABCD;
        run_frame(8'd2, 1'b0, 2);
`ifdef CODE_LOADER_CHECKSUM_EN
        run_frame(8'd2, 1'b1, 2);
        run_frame(8'd2, 1'b0, 2);
`endif

        // Garbage outside a frame causes no writes.
        send_byte(8'h00, 3);
        send_byte(8'hFF, 3);
        send_byte(8'h5A, 3);
        frame_words[0] = 16'h0000;
        run_frame(8'd1, 1'b0, 3);

        // Address wrap FE, FF, 00 and START_BYTE values carried as data.
        frame_words[0] = 16'h1111;
        frame_words[1] = 16'h2222;
        frame_words[2] = 16'h3333;
        frame_words[3] = 16'hA5A5;
        run_frame(8'd4, 1'b0, 5);

        // Reset in the middle of word 2 of a 4-word load.
        send_byte(START, 2);
        send_byte(8'd4, 2);
        exp_q.push_back({BASE, 16'hBEEF});
        send_byte(8'hBE, 2);
        send_byte(8'hEF, 2);
        send_byte(8'h77, 2);
        check("hold_before_reset", {31'd0, CPU_HOLD}, 32'd1);
        RESET = 1'b1;
        tick();
        check_reset_values("midload_reset");
        RESET = 1'b0;
        repeat (4) tick();
        check_reset_values("after_reset");
        check("reset_writes_outstanding", exp_q.size(), 32'd0);
        frame_words[0] = 16'hCAFE;
        frame_words[1] = 16'hF00D;
        frame_words[2] = 16'h0102;
        frame_words[3] = 16'hFFFF;
        run_frame(8'd4, 1'b0, 5);

        // Randomized frames with random gaps.
        for (int t = 0; t < 10; t++) begin
            n = 8'($urandom_range(12, 1));
            for (int i = 0; i < 12; i++) frame_words[i] = 16'($urandom);
`ifdef CODE_LOADER_CHECKSUM_EN
            bad = ($urandom_range(3, 0) == 0);
`else
            bad = 1'b0;
`endif
            run_frame(n, bad, 5);
        end

        // N=0 means 256 words, wrapping the whole address space.
        for (int i = 0; i < 256; i++) frame_words[i] = 16'($urandom);
        run_frame(8'd0, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
